// File: rtl/vc_allocator_if.sv
// Bundle between the router input ports and the VC allocator. The input-port side
// (master) raises head-flit requests and downstream releases; the allocator (slave)
// answers with one-cycle grant pulses carrying the granted downstream VC id.
interface vc_allocator_if #(
  parameter int unsigned VcNum   = 2,
  parameter int unsigned PortNum = 5
);

  localparam int unsigned VcSize = (VcNum > 1) ? $clog2(VcNum) : 1;
  localparam int unsigned PortW  = (PortNum > 1) ? $clog2(PortNum) : 1;

  // [p][v]: input VC v of port p holds a head flit that needs a downstream VC
  logic [PortNum-1:0][VcNum-1:0]             vc_request;
  // [p][v]: routed output port of that head flit
  logic [PortNum-1:0][VcNum-1:0][PortW-1:0]  out_port;
  // [o][w]: one-cycle pulse, downstream VC w behind output o has been freed
  logic [PortNum-1:0][VcNum-1:0]             idle_downstream_vc;
  // [p][v]: one-cycle grant pulse
  logic [PortNum-1:0][VcNum-1:0]             vc_valid;
  // [p][v]: granted downstream VC id, meaningful only with vc_valid
  logic [PortNum-1:0][VcNum-1:0][VcSize-1:0] vc_new;

  modport master (
    output vc_request,
    output out_port,
    output idle_downstream_vc,
    input  vc_valid,
    input  vc_new
  );

  modport slave (
    input  vc_request,
    input  out_port,
    input  idle_downstream_vc,
    output vc_valid,
    output vc_new
  );

endinterface

// File: rtl/vc_allocator.sv
// Virtual-channel allocator. Keeps a free bit per downstream VC of every output port,
// runs one round-robin arbiter per output port over all input VCs, and hands the
// lowest free downstream VC to each winner. Grants are registered: a request sampled
// at one edge produces a single-cycle vc_valid pulse after that edge.
module vc_allocator #(
  parameter int unsigned VcNum   = 2,
  parameter int unsigned PortNum = 5
) (
  input  logic          clk,
  input  logic          rst,
  vc_allocator_if.slave bus
);

  localparam int unsigned VcSize = (VcNum > 1) ? $clog2(VcNum) : 1;
  localparam int unsigned PortW  = (PortNum > 1) ? $clog2(PortNum) : 1;
  // Requester r = p*VcNum + v; this matches the bit order of the packed [p][v] arrays.
  localparam int unsigned ReqNum = PortNum * VcNum;
  localparam int unsigned PtrW   = (ReqNum > 1) ? $clog2(ReqNum) : 1;

  typedef logic [PortNum-1:0][VcNum-1:0] vc_mask_t;
  typedef logic [ReqNum-1:0]             req_vec_t;
  typedef logic [PtrW-1:0]               ptr_t;
  typedef logic [VcSize-1:0]             vc_id_t;

  // Registered state
  vc_mask_t                 avail_q, avail_d;
  logic [PortNum-1:0][PtrW-1:0] rr_q, rr_d;
  req_vec_t                 vc_valid_q, vc_valid_d;
  logic [ReqNum-1:0][VcSize-1:0] vc_new_q, vc_new_d;

  // Combinational arbitration results, one entry per output port
  req_vec_t                 eligible;
  req_vec_t                 req_by_out [PortNum];
  logic     [PortNum-1:0]   grant_en;
  ptr_t                     grant_win  [PortNum];
  vc_id_t                   grant_vc   [PortNum];

  // First set bit of req at or after ptr, wrapping around the requester range.
  function automatic ptr_t rr_pick(input req_vec_t req, input ptr_t ptr);
    ptr_t        pick;
    logic        hit;
    int unsigned idx;
    pick = '0;
    hit  = 1'b0;
    for (int unsigned k = 0; k < ReqNum; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= ReqNum) begin
        idx = idx - ReqNum;
      end
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        pick = ptr_t'(idx);
      end
    end
    return pick;
  endfunction

  // Lowest-index set bit; scanning downwards leaves the lowest one selected.
  function automatic vc_id_t first_free(input logic [VcNum-1:0] free);
    vc_id_t sel;
    sel = '0;
    for (int w = int'(VcNum) - 1; w >= 0; w--) begin
      if (free[w]) begin
        sel = vc_id_t'(w);
      end
    end
    return sel;
  endfunction

  // Pointer advance past the winner, modulo the requester count.
  function automatic ptr_t ptr_after(input ptr_t win);
    ptr_t nxt;
    if (32'(win) == ReqNum - 1) begin
      nxt = '0;
    end else begin
      nxt = win + 1'b1;
    end
    return nxt;
  endfunction

  // A requester that is being granted this cycle is masked so it is never granted twice.
  always_comb begin
    eligible = bus.vc_request & ~vc_valid_q;
  end

  // Split eligible requesters by the output port their head flit is routed to.
  always_comb begin
    for (int unsigned o = 0; o < PortNum; o++) begin
      req_by_out[o] = '0;
      for (int unsigned r = 0; r < ReqNum; r++) begin
        req_by_out[o][r] = eligible[r] &&
                           (bus.out_port[r / VcNum][r % VcNum] == PortW'(o));
      end
    end
  end

  // Per-output arbitration: only registered availability is used, so a release
  // arriving this cycle is not bypassed into this cycle's allocation.
  always_comb begin
    for (int unsigned o = 0; o < PortNum; o++) begin
      grant_en[o]  = (|avail_q[o]) && (|req_by_out[o]);
      grant_win[o] = rr_pick(req_by_out[o], rr_q[o]);
      grant_vc[o]  = first_free(avail_q[o]);
    end
  end

  // Next-state: apply releases, consume granted VCs, advance pointers, form grant pulses.
  always_comb begin
    avail_d    = avail_q | bus.idle_downstream_vc;
    rr_d       = rr_q;
    vc_valid_d = '0;
    vc_new_d   = '0;
    for (int unsigned o = 0; o < PortNum; o++) begin
      if (grant_en[o]) begin
        // Each requester targets a single output, so no two ports write the same index.
        vc_valid_d[grant_win[o]]        = 1'b1;
        vc_new_d[grant_win[o]]          = grant_vc[o];
        avail_d[o][grant_vc[o]]         = 1'b0;
        rr_d[o]                         = ptr_after(grant_win[o]);
      end
    end
  end

  // State registers with synchronous active-low reset; reset drops in-flight grants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      avail_q    <= '1;
      rr_q       <= '0;
      vc_valid_q <= '0;
      vc_new_q   <= '0;
    end else begin
      avail_q    <= avail_d;
      rr_q       <= rr_d;
      vc_valid_q <= vc_valid_d;
      vc_new_q   <= vc_new_d;
    end
  end

  // Grant outputs come straight from registers; flat requester order equals [p][v] packing.
  always_comb begin
    bus.vc_valid = vc_valid_q;
    bus.vc_new   = vc_new_q;
  end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator: reset state, single grant, exhaustion and release,
// round-robin fairness, parallel grants, simultaneous release/allocate, reset mid-run.
module tb_vc_allocator;

  localparam int Local = 0;
  localparam int North = 1;
  localparam int South = 2;
  localparam int West  = 3;
  localparam int East  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  vc_allocator_if bus ();

  vc_allocator u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.vc_request         = '0;
    bus.out_port           = '0;
    bus.idle_downstream_vc = '0;
  endtask

  task automatic req(input int p, input int v, input int o);
    bus.vc_request[p][v] = 1'b1;
    bus.out_port[p][v]   = 3'(o);
  endtask

  task automatic drop(input int p, input int v);
    bus.vc_request[p][v] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    check("reset_valid", 32'(bus.vc_valid), 32'h0);
    check("reset_new", 32'(bus.vc_new), 32'h0);
    check("reset_avail", 32'(u_dut.avail_q), 32'h3ff);
    check("reset_rr", 32'(u_dut.rr_q), 32'h0);
    rst = 1'b1;
    tick();
    check("no_req_no_grant", 32'(bus.vc_valid), 32'h0);

    // T1: single request LOCAL[0] -> EAST
    req(Local, 0, East);
    tick();
    check("t1_valid", 32'(bus.vc_valid), 32'h001);
    check("t1_new", 32'(bus.vc_new[Local][0]), 32'h0);
    check("t1_avail_east", 32'(u_dut.avail_q[East]), 32'h2);
    drop(Local, 0);
    tick();
    check("t1_pulse_len", 32'(bus.vc_valid), 32'h0);
    check("t1_rr_east", 32'(u_dut.rr_q[East]), 32'h1);

    // Release of an already-free VC leaves it free
    bus.idle_downstream_vc[Local][0] = 1'b1;
    tick();
    bus.idle_downstream_vc[Local][0] = 1'b0;
    check("redundant_release", 32'(u_dut.avail_q[Local]), 32'h3);

    // T2: exhaustion and release on EAST
    do_reset();
    req(Local, 0, East);
    req(North, 0, East);
    req(South, 0, East);
    tick();
    check("t2_local_valid", 32'(bus.vc_valid), 32'h001);
    check("t2_local_new", 32'(bus.vc_new[Local][0]), 32'h0);
    drop(Local, 0);
    tick();
    check("t2_north_valid", 32'(bus.vc_valid), 32'h004);
    check("t2_north_new", 32'(bus.vc_new[North][0]), 32'h1);
    drop(North, 0);
    tick();
    check("t2_full_wait1", 32'(bus.vc_valid), 32'h0);
    tick();
    check("t2_full_wait2", 32'(bus.vc_valid), 32'h0);
    check("t2_rr_east", 32'(u_dut.rr_q[East]), 32'h3);
    bus.idle_downstream_vc[East][1] = 1'b1;
    tick();
    check("t2_no_bypass", 32'(bus.vc_valid), 32'h0);
    bus.idle_downstream_vc[East][1] = 1'b0;
    tick();
    check("t2_south_valid", 32'(bus.vc_valid), 32'h010);
    check("t2_south_new", 32'(bus.vc_new[South][0]), 32'h1);
    drop(South, 0);
    tick();
    check("t2_east_empty", 32'(u_dut.avail_q[East]), 32'h0);

    // T3: fairness between NORTH[0] and SOUTH[0] towards WEST
    do_reset();
    req(North, 0, West);
    req(South, 0, West);
    tick();
    check("t3_g1_valid", 32'(bus.vc_valid), 32'h004);
    check("t3_g1_new", 32'(bus.vc_new[North][0]), 32'h0);
    bus.idle_downstream_vc[West][0] = 1'b1;
    tick();
    check("t3_g2_valid", 32'(bus.vc_valid), 32'h010);
    check("t3_g2_new", 32'(bus.vc_new[South][0]), 32'h1);
    bus.idle_downstream_vc[West][0] = 1'b0;
    bus.idle_downstream_vc[West][1] = 1'b1;
    tick();
    check("t3_g3_valid", 32'(bus.vc_valid), 32'h004);
    check("t3_g3_new", 32'(bus.vc_new[North][0]), 32'h0);
    bus.idle_downstream_vc[West][1] = 1'b0;
    bus.idle_downstream_vc[West][0] = 1'b1;
    drop(North, 0);
    drop(South, 0);
    tick();
    bus.idle_downstream_vc[West][0] = 1'b0;
    tick();
    check("t3_quiet", 32'(bus.vc_valid), 32'h0);
    check("t3_west_free", 32'(u_dut.avail_q[West]), 32'h3);

    // T4: one requester per output port, all granted together
    do_reset();
    req(Local, 0, East);
    req(North, 0, West);
    req(South, 0, Local);
    req(West, 0, North);
    req(East, 0, South);
    tick();
    check("t4_valid", 32'(bus.vc_valid), 32'h155);
    check("t4_new", 32'(bus.vc_new), 32'h0);
    clear_inputs();
    tick();
    check("t4_pulse_len", 32'(bus.vc_valid), 32'h0);

    // T5: release EAST VC0 while requesting EAST with only VC1 free
    do_reset();
    req(Local, 0, East);
    tick();
    check("t5_setup_valid", 32'(bus.vc_valid), 32'h001);
    drop(Local, 0);
    bus.idle_downstream_vc[East][0] = 1'b1;
    req(North, 1, East);
    tick();
    check("t5_valid", 32'(bus.vc_valid), 32'h008);
    check("t5_new", 32'(bus.vc_new[North][1]), 32'h1);
    bus.idle_downstream_vc[East][0] = 1'b0;
    drop(North, 1);
    tick();
    check("t5_avail_east", 32'(u_dut.avail_q[East]), 32'h1);
    req(Local, 1, East);
    tick();
    check("t5_vc0_valid", 32'(bus.vc_valid), 32'h002);
    check("t5_vc0_new", 32'(bus.vc_new[Local][1]), 32'h0);
    drop(Local, 1);
    tick();

    // T6: reset with EAST fully allocated and a grant about to issue
    req(West, 0, East);
    req(South, 1, North);
    rst = 1'b0;
    tick();
    check("t6_valid_dropped", 32'(bus.vc_valid), 32'h0);
    check("t6_avail_reset", 32'(u_dut.avail_q), 32'h3ff);
    check("t6_rr_reset", 32'(u_dut.rr_q), 32'h0);
    drop(South, 1);
    rst = 1'b1;
    tick();
    check("t6_east_valid", 32'(bus.vc_valid), 32'h040);
    check("t6_east_new", 32'(bus.vc_new[West][0]), 32'h0);
    check("t6_rr_east", 32'(u_dut.rr_q[East]), 32'h7);
    clear_inputs();
    tick();
    check("t6_quiet", 32'(bus.vc_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
